// File: rtl/ex_mdu_sequencer_if.sv
// ex_mdu_sequencer_if: handshake/bus bundle between the EX stage and the M-extension sequencer
//   flush, startIn, mdOpIn[2:0], srcAIn, srcBIn : request side (EX -> sequencer)
//   stallOut, doneOut, resultOut                : response side (sequencer -> EX)
interface ex_mdu_sequencer_if #(parameter int BUS_W = 32);
    logic             flush;
    logic             startIn;
    logic [2:0]       mdOpIn;
    logic [BUS_W-1:0] srcAIn;
    logic [BUS_W-1:0] srcBIn;
    logic             stallOut;
    logic             doneOut;
    logic [BUS_W-1:0] resultOut;
    modport master (output flush, startIn, mdOpIn, srcAIn, srcBIn, input stallOut, doneOut, resultOut);
    modport slave (input flush, startIn, mdOpIn, srcAIn, srcBIn, output stallOut, doneOut, resultOut);
endinterface

// File: rtl/ex_mdu_sequencer.sv
// ex_mdu_sequencer: iterative RV32M multiply/divide, one bit per cycle, stalls the pipeline while busy
//   clk : rising-edge clock      rst : asynchronous active-low reset
//   m   : slave side of ex_mdu_sequencer_if (flush/start/op/operands in, stall/done/result out)
module ex_mdu_sequencer #(parameter int BUS_W = 32) (
    input logic clk,
    input logic rst,
    ex_mdu_sequencer_if.slave m
);
    localparam int W  = BUS_W;
    localparam int CW = $clog2(BUS_W);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state, state_n;
    logic [2:0]     op;
    logic           neg;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   opnd;
    logic [2*W-1:0] acc, mul_next, div_next, prod;
    logic [W:0]     sum, trial;
    logic [W-1:0]   mag_a, mag_b, fast_val, quo, fixed;
    logic           sa, sb, div_zero, ovf, fast, accept;
    always_comb begin
        sa       = m.srcAIn[W-1] & (m.mdOpIn == 3'b001 || m.mdOpIn == 3'b010 || (m.mdOpIn[2] && !m.mdOpIn[0]));
        sb       = m.srcBIn[W-1] & (m.mdOpIn == 3'b001 || (m.mdOpIn[2] && !m.mdOpIn[0]));
        mag_a    = sa ? -m.srcAIn : m.srcAIn;
        mag_b    = sb ? -m.srcBIn : m.srcBIn;
        div_zero = m.mdOpIn[2] && m.srcBIn == '0;
        ovf      = m.mdOpIn[2] && !m.mdOpIn[0] && m.srcAIn == {1'b1, {(W-1){1'b0}}} && &m.srcBIn;
        fast     = div_zero || ovf;
        fast_val = div_zero ? (m.mdOpIn[1] ? m.srcAIn : '1) : (m.mdOpIn[1] ? '0 : m.srcAIn);
        accept   = state == IDLE && m.startIn && !m.flush;
        // shift-add: multiplier sits in the low half and is consumed from bit 0
        sum      = {1'b0, acc[2*W-1:W]} + ({1'b0, opnd} & {(W+1){acc[0]}});
        mul_next = {sum, acc[W-1:1]};
        // restoring divide on {remainder, quotient}; bit W of the trial flags a borrow
        trial    = acc[2*W-1:W-1] - {1'b0, opnd};
        div_next = trial[W] ? {acc[2*W-2:0], 1'b0} : {trial[W-1:0], acc[W-2:0], 1'b1};
        prod     = neg ? -acc : acc;
        quo      = op[1] ? acc[2*W-1:W] : acc[W-1:0];
        fixed    = op[2] ? (neg ? -quo : quo) : (op[1:0] == 2'b00 ? prod[W-1:0] : prod[2*W-1:W]);
        state_n  = m.flush ? IDLE :
                   state == IDLE ? (m.startIn ? (fast ? DONE : CALC) : IDLE) :
                   state == CALC ? (cnt == '0 ? FIX : CALC) :
                   state == FIX  ? DONE : IDLE;
        m.stallOut = !m.flush && (accept || state == CALC || state == FIX);
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_n;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op          <= '0;
            neg         <= 1'b0;
            cnt         <= '0;
            opnd        <= '0;
            acc         <= '0;
            m.doneOut   <= 1'b0;
            m.resultOut <= '0;
        end else begin
            m.doneOut <= state_n == DONE;
            if (accept) begin
                op   <= m.mdOpIn;
                neg  <= sa ^ (sb & !(m.mdOpIn[2] && m.mdOpIn[1]));
                cnt  <= CW'(W-1);
                opnd <= m.mdOpIn[2] ? mag_b : mag_a;
                acc  <= {{W{1'b0}}, m.mdOpIn[2] ? mag_a : mag_b};
                if (fast) m.resultOut <= fast_val;
            end else if (state == CALC) begin
                acc <= op[2] ? div_next : mul_next;
                if (cnt != '0) cnt <= cnt - 1'b1;
            end else if (state == FIX && !m.flush) begin
                m.resultOut <= fixed;
            end
        end
    end
endmodule

// File: tb/tb_ex_mdu_sequencer.sv
// tb_ex_mdu_sequencer: directed self-checking bench for ex_mdu_sequencer
module tb_ex_mdu_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    ex_mdu_sequencer_if #(.BUS_W(32)) m ();
    ex_mdu_sequencer #(.BUS_W(32)) dut (.clk(clk), .rst(rst), .m(m));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // starts an op in the current cycle (cycle 0) and returns in the cycle doneOut is seen
    task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input logic [31:0] expv, input bit hold);
        int dc;
        int sbad;
        m.mdOpIn = op;
        m.srcAIn = a;
        m.srcBIn = b;
        m.startIn = 1'b1;
        #1;
        dc = -1;
        sbad = 0;
        for (int c = 0; c <= lat + 8 && dc < 0; c++) begin
            if (c > 0) begin
                tick();
                if (!hold) m.startIn = 1'b0;
                #1;
            end
            if (m.stallOut !== ((c < lat) ? 1'b1 : 1'b0)) sbad++;
            if (m.doneOut === 1'b1) dc = c;
        end
        chk($sformatf("%s.done_cycle", tag), dc, lat);
        chk($sformatf("%s.stall_bad", tag), sbad, 0);
        chk($sformatf("%s.result", tag), m.resultOut, expv);
    endtask
    initial begin
        int sbad;
        m.flush = 1'b0;
        m.startIn = 1'b0;
        m.mdOpIn = 3'b000;
        m.srcAIn = '0;
        m.srcBIn = '0;
        #1;
        chk("rst.stall", {31'd0, m.stallOut}, 0);
        chk("rst.done", {31'd0, m.doneOut}, 0);
        chk("rst.result", m.resultOut, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        run("mul", 3'b000, 32'd7, 32'd6, 34, 32'h0000_002A, 1'b0);
        tick();
        chk("mul.done_after", {31'd0, m.doneOut}, 0);
        tick();
        run("mulh", 3'b001, 32'hFFFF_FFFE, 32'd3, 34, 32'hFFFF_FFFF, 1'b0);
        tick();
        run("mulhu", 3'b011, 32'hFFFF_FFFE, 32'd3, 34, 32'h0000_0002, 1'b0);
        tick();
        run("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFF, 1'b0);
        tick();
        run("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFD, 1'b0);
        tick();
        run("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 1'b0);
        tick();
        run("divu", 3'b101, 32'd100, 32'd7, 34, 32'd14, 1'b0);
        tick();
        run("remu", 3'b111, 32'd100, 32'd7, 34, 32'd2, 1'b0);
        tick();
        run("divu0", 3'b101, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 1'b0);
        tick();
        run("rem0", 3'b110, 32'd5, 32'd0, 1, 32'd5, 1'b0);
        tick();
        run("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 1'b0);
        tick();
        m.mdOpIn = 3'b100;
        m.srcAIn = 32'd1000;
        m.srcBIn = 32'd3;
        m.startIn = 1'b1;
        #1;
        sbad = (m.stallOut === 1'b1) ? 0 : 1;
        for (int c = 1; c < 10; c++) begin
            tick();
            m.startIn = 1'b0;
            #1;
            if (m.stallOut !== 1'b1 || m.doneOut !== 1'b0) sbad++;
        end
        chk("flush.pre_stall_bad", sbad, 0);
        tick();
        m.flush = 1'b1;
        #1;
        chk("flush.stall_c10", {31'd0, m.stallOut}, 0);
        tick();
        m.flush = 1'b0;
        #1;
        chk("flush.stall_c11", {31'd0, m.stallOut}, 0);
        chk("flush.done_c11", {31'd0, m.doneOut}, 0);
        chk("flush.result_kept", m.resultOut, 32'h8000_0000);
        tick();
        run("flush.mul", 3'b000, 32'd9, 32'd9, 34, 32'd81, 1'b0);
        tick();
        m.mdOpIn = 3'b000;
        m.srcAIn = 32'd7;
        m.srcBIn = 32'd6;
        m.startIn = 1'b1;
        #1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            m.startIn = 1'b0;
            #1;
        end
        rst = 1'b0;
        #1;
        chk("rstmid.stall", {31'd0, m.stallOut}, 0);
        chk("rstmid.done", {31'd0, m.doneOut}, 0);
        chk("rstmid.result", m.resultOut, 0);
        tick();
        rst = 1'b1;
        #1;
        chk("rstmid.idle_stall", {31'd0, m.stallOut}, 0);
        tick();
        run("hold1", 3'b000, 32'd3, 32'd5, 34, 32'd15, 1'b1);
        tick();
        run("hold2", 3'b101, 32'd100, 32'd7, 34, 32'd14, 1'b0);
        tick();
        m.mdOpIn = 3'b000;
        m.startIn = 1'b1;
        m.flush = 1'b1;
        #1;
        chk("flushstart.stall", {31'd0, m.stallOut}, 0);
        tick();
        m.startIn = 1'b0;
        m.flush = 1'b0;
        #1;
        chk("flushstart.stall_next", {31'd0, m.stallOut}, 0);
        chk("flushstart.done_next", {31'd0, m.doneOut}, 0);
        tick();
        chk("flushstart.stall_idle", {31'd0, m.stallOut}, 0);
        chk("flushstart.result", m.resultOut, 32'd14);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ex_mdu_sequencer.md
Name: ex_mdu_sequencer

Overview:
- Iterative RV32M multiply/divide controller and datapath beside the single-cycle EX ALU.
- Accepts one M-extension op from decode/EX and sequences a radix-2 shift-add multiply or restoring divide, one bit per cycle.
- Raises a stall toward the pipeline while working, then presents the result for one cycle so the EX/MEM register captures it.
- Honours pipeline flush.

Parameters:
- BUS_W, 32, operand/result width; iteration count equals BUS_W.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- flush  input  1  pipeline flush; aborts any op in progress.
- startIn  input  1  request a new op; sampled in IDLE only.
- mdOpIn  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- srcAIn  input  BUS_W  rs1 value (multiplicand/dividend).
- srcBIn  input  BUS_W  rs2 value (multiplier/divisor).
- stallOut  output  1  hold upstream stages; combinational.
- doneOut  output  1  result valid this cycle; registered.
- resultOut  output  BUS_W  op result; registered, held until next accepted start.

Behaviour:
- Reset (rst low, any time, including mid-op):
  - state IDLE, counter 0, doneOut 0, resultOut 0, internal operand/accumulator regs 0.
  - stallOut 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - Accept when startIn=1 and flush=0.
  - Latch op and operand magnitudes.
    - Signed operands: DIV/REM/MULH both signed. MULHSU: srcA signed, srcB unsigned.
  - Record result sign: product sign; quotient sign = signA xor signB; remainder sign = signA.
  - Load counter with BUS_W-1 and go to CALC.
- CALC:
  - One iteration per cycle.
    - Multiply: 2*BUS_W accumulator.
    - Divide: restoring divide using a BUS_W+1-bit subtract.
  - At counter 0 go to FIX; otherwise decrement.
- FIX:
  - Apply two's-complement sign correction.
  - Select the result: low half for MUL, high half for MULH*; quotient or remainder for div ops.
  - Write resultOut; go to DONE.
- DONE: doneOut=1 for exactly one cycle; go to IDLE.
- Fast path, decided in the accept cycle; go directly to DONE with resultOut written at that edge:
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give srcA.
  - Signed overflow (srcA = 0x8000_0000, srcB = all-ones): DIV gives 0x8000_0000; REM gives 0.
- Timing (cycle 0 = cycle startIn accepted):
  - Normal op:
    - stallOut=1 in cycles 0..BUS_W+1.
    - doneOut=1 and stallOut=0 in cycle BUS_W+2 (34 for BUS_W=32).
  - Fast path: stallOut=1 in cycle 0 only; doneOut=1 in cycle 1.
- stallOut = (state==IDLE && startIn && !flush) || state==CALC || state==FIX.
- flush:
  - From any state: next state IDLE, doneOut 0 next cycle, resultOut unchanged.
  - stallOut is forced 0 in the same cycle.
  - flush and startIn together: flush wins, nothing accepted.
- startIn outside IDLE is ignored, including in DONE; a back-to-back op is accepted the cycle after DONE.
- Arithmetic is modulo 2^BUS_W on the selected half; no exceptions are raised.

Test Plan:
- Reset, then MUL 7*6 (start cycle 0) -> stallOut high cycles 0..33; doneOut high only in cycle 34; resultOut=0x0000_002A.
- MULH 0xFFFF_FFFE*3 -> 0xFFFF_FFFF. MULHU same operands -> 0x0000_0002. MULHSU 0xFFFF_FFFF*0xFFFF_FFFF -> 0xFFFF_FFFF.
- DIV 0xFFFF_FFF9/2 -> 0xFFFF_FFFD. REM same operands -> 0xFFFF_FFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> doneOut cycle 1, result 0xFFFF_FFFF. REM 5/0 -> 5. DIV 0x8000_0000/0xFFFF_FFFF -> 0x8000_0000, doneOut cycle 1.
- Flush in cycle 10 of a DIV:
  - stallOut 0 in cycle 10; state IDLE from cycle 11; no doneOut.
  - resultOut keeps its previous value.
  - A new MUL started in cycle 12 completes in cycle 46.
- rst low in cycle 20 of a MUL -> outputs 0 immediately.
- startIn held high throughout a run -> second op accepted the cycle after doneOut; same-cycle startIn with flush is not accepted.
